// File: rtl/audio_route_fader.sv
// audio_route_fader: selects one of NUM_SRC stereo PCM streams. Every source
// change is made click-free by fading the old source down to silence,
// switching in one idle cycle, and fading the new source back up.
//
// Handshake: src_valid[i] is a one-cycle strobe; only the strobe of the source
// in active_sel is accepted. There is no backpressure. Each accepted sample
// produces one out_valid pulse one cycle later, carrying L and R together.
module audio_route_fader #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int DATA_W  = 24,
  parameter int RAMP_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [SEL_W-1:0]          select,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_l_data,
  input  logic [NUM_SRC*DATA_W-1:0] src_r_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_l_data,
  output logic [DATA_W-1:0]         out_r_data,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_PASS      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_SWITCH    = 3'd4
  } state_t;

  localparam int              PW          = DATA_W + RAMP_W + 2;
  localparam logic [RAMP_W:0] RAMP_MAX    = {1'b1, {RAMP_W{1'b0}}};
  localparam logic [RAMP_W:0] RAMP_MAX_M1 = RAMP_MAX - 1'b1;
  localparam logic [RAMP_W:0] GAIN_ONE    = (RAMP_W+1)'(1);
  localparam logic [SEL_W:0]  NUM_SRC_W   = (SEL_W+1)'(NUM_SRC);

  state_t              state_q, state_d;
  logic [RAMP_W:0]     gain_q, gain_d;
  logic [SEL_W-1:0]    target_q, target_d;
  logic [SEL_W-1:0]    active_q, active_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_l_q, out_l_d;
  logic [DATA_W-1:0]   out_r_q, out_r_d;

  logic                accepted;
  logic signed [DATA_W-1:0] sample_l, sample_r;
  logic signed [RAMP_W+1:0] gain_s;
  logic signed [PW-1:0]     prod_l, prod_r;
  logic [DATA_W-1:0]        faded_l, faded_r;
  logic                     unused_prod_bits;

  // Out-of-range select values leave the routing target untouched.
  always_comb begin
    target_d = target_q;
    if ({1'b0, select} < NUM_SRC_W) target_d = select;
  end

  // Pick the strobe and samples of the currently routed source.
  always_comb begin
    accepted = 1'b0;
    sample_l = '0;
    sample_r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_q == SEL_W'(i)) begin
        accepted = src_valid[i];
        sample_l = src_l_data[i*DATA_W +: DATA_W];
        sample_r = src_r_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Signed gain multiply; taking bits above RAMP_W is an arithmetic shift
  // right, i.e. rounding toward negative infinity.
  assign gain_s  = {1'b0, gain_q};
  assign prod_l  = PW'(sample_l) * PW'(gain_s);
  assign prod_r  = PW'(sample_r) * PW'(gain_s);
  assign faded_l = prod_l[RAMP_W +: DATA_W];
  assign faded_r = prod_r[RAMP_W +: DATA_W];
  assign unused_prod_bits = ^{prod_l[RAMP_W-1:0], prod_l[PW-1 -: 2],
                              prod_r[RAMP_W-1:0], prod_r[PW-1 -: 2]};

  // Next-state, gain stepping and output sample generation.
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    active_d    = active_q;
    out_valid_d = 1'b0;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    if (!run) begin
      // Disable is immediate: no fade-out, data forced to silence.
      state_d = ST_STOPPED;
      gain_d  = '0;
      out_l_d = '0;
      out_r_d = '0;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          active_d = target_q;
          gain_d   = '0;
          state_d  = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (accepted) begin
            out_valid_d = 1'b1;
            out_l_d     = faded_l;
            out_r_d     = faded_r;
            gain_d      = gain_q + 1'b1;
            if (gain_q == RAMP_MAX_M1) state_d = ST_PASS;
          end
          // A new target wins over reaching full gain; fade from wherever we are.
          if (target_q != active_q) state_d = ST_RAMP_DOWN;
        end
        ST_PASS: begin
          if (accepted) begin
            out_valid_d = 1'b1;
            out_l_d     = faded_l;
            out_r_d     = faded_r;
          end
          if (target_q != active_q) state_d = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          // Target changes are ignored here; the ramp always completes.
          if (gain_q == '0) begin
            state_d = ST_SWITCH;
          end else if (accepted) begin
            out_valid_d = 1'b1;
            out_l_d     = faded_l;
            out_r_d     = faded_r;
            gain_d      = gain_q - 1'b1;
            if (gain_q == GAIN_ONE) state_d = ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          // One silent cycle; any strobe here is dropped.
          active_d = target_q;
          gain_d   = '0;
          state_d  = ST_RAMP_UP;
        end
        default: state_d = ST_STOPPED;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STOPPED;
      gain_q      <= '0;
      target_q    <= '0;
      active_q    <= '0;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      target_q    <= target_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_l_data = out_l_q;
  assign out_r_data = out_r_q;
  assign active_sel = active_q;
  assign busy       = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                      (state_q == ST_SWITCH);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_audio_route_fader.sv
// Directed testbench for audio_route_fader with three sources, 24-bit data and
// 16 ramp steps. Expected samples come from a floor-division gain model.
module tb_audio_route_fader;

  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 24;
  localparam int RAMP_W  = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                      run;
  logic [SEL_W-1:0]          select;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_l_data;
  logic [NUM_SRC*DATA_W-1:0] src_r_data;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_l_data;
  logic [DATA_W-1:0]         out_r_data;
  logic [SEL_W-1:0]          active_sel;
  logic                      busy;
  logic [2:0]                dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int src_l[NUM_SRC];
  int src_r[NUM_SRC];

  audio_route_fader #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DATA_W(DATA_W), .RAMP_W(RAMP_W)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .select(select),
    .src_valid(src_valid), .src_l_data(src_l_data), .src_r_data(src_r_data),
    .out_valid(out_valid), .out_l_data(out_l_data), .out_r_data(out_r_data),
    .active_sel(active_sel), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference gain: v * g / 16 rounded toward negative infinity.
  function automatic logic [DATA_W-1:0] scale(input int v, input int g);
    longint p, q;
    p = longint'(v) * g;
    if (p >= 0) q = p / 16;
    else        q = -((-p + 15) / 16);
    return q[DATA_W-1:0];
  endfunction

  // Driver tasks
  task automatic set_src(input int i, input int l, input int r);
    src_l[i] = l;
    src_r[i] = r;
    src_l_data[i*DATA_W +: DATA_W] = l[DATA_W-1:0];
    src_r_data[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe every source; only the active one should be taken.
  task automatic strobe_chk(input string tag, input int src, input int g);
    src_valid = '1;
    step();
    src_valid = '0;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_l"}, 32'(out_l_data), 32'(scale(src_l[src], g)));
    check_eq({tag, "_r"}, 32'(out_r_data), 32'(scale(src_r[src], g)));
  endtask

  task automatic silent_step(input string tag);
    src_valid = '1;
    step();
    src_valid = '0;
    check_eq(tag, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    run        = 1'b0;
    select     = '0;
    src_valid  = '0;
    src_l_data = '0;
    src_r_data = '0;
    set_src(0, 'h100000, -'h100000);
    set_src(1, 'h123456, 'h654321);
    set_src(2, -'h800000, 'h400000);

    // Reset values
    #2;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_l", 32'(out_l_data), 32'd0);
    check_eq("rst_r", 32'(out_r_data), 32'd0);
    check_eq("rst_active", 32'(active_sel), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    silent_step("stopped_no_out");

    // Pass-through ramp-up on source 0
    run = 1'b1;
    select = 2'd0;
    step();
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_active", 32'(active_sel), 32'd0);
    src_valid = 3'b010;
    step();
    src_valid = '0;
    check_eq("other_src_ignored", 32'(out_valid), 32'd0);
    for (int g = 0; g < 16; g++) strobe_chk("ramp_up0", 0, g);
    check_eq("pass_busy", 32'(busy), 32'd0);
    step();
    check_eq("hold_valid", 32'(out_valid), 32'd0);
    check_eq("hold_l", 32'(out_l_data), 32'h0F0000);
    strobe_chk("pass0", 0, 16);
    check_eq("pass0_exact", 32'(out_l_data), 32'h100000);

    // Full switch 0 -> 2
    set_src(0, 'h7FFFFF, -'h7FFFFF);
    select = 2'd2;
    step();
    check_eq("sw_target_lat_busy", 32'(busy), 32'd0);
    step();
    check_eq("sw_down_busy", 32'(busy), 32'd1);
    for (int g = 16; g >= 1; g--) strobe_chk("down0", 0, g);
    silent_step("switch_dropped");
    check_eq("switch_active", 32'(active_sel), 32'd2);
    for (int g = 0; g < 16; g++) strobe_chk("up2", 2, g);
    check_eq("pass2_busy", 32'(busy), 32'd0);
    strobe_chk("pass2", 2, 16);
    check_eq("pass2_exact", 32'(out_l_data), 32'h800000);

    // Out-of-range select is ignored
    select = 2'd3;
    repeat (3) step();
    check_eq("oor_active", 32'(active_sel), 32'd2);
    check_eq("oor_busy", 32'(busy), 32'd0);

    // Reversal during ramp-up
    select = 2'd0;
    step();
    step();
    for (int g = 16; g >= 1; g--) strobe_chk("down2", 2, g);
    silent_step("rev_switch1");
    check_eq("rev_active0", 32'(active_sel), 32'd0);
    for (int g = 0; g < 5; g++) strobe_chk("rev_up0", 0, g);
    select = 2'd2;
    step();
    step();
    check_eq("rev_busy", 32'(busy), 32'd1);
    for (int g = 5; g >= 1; g--) strobe_chk("rev_down0", 0, g);
    silent_step("rev_switch2");
    check_eq("rev_active2", 32'(active_sel), 32'd2);
    strobe_chk("rev_up2_g0", 2, 0);
    strobe_chk("rev_up2_g1", 2, 1);

    // Disable mid ramp-down
    select = 2'd0;
    step();
    step();
    strobe_chk("dis_down", 2, 2);
    run = 1'b0;
    silent_step("dis_valid");
    check_eq("dis_l", 32'(out_l_data), 32'd0);
    check_eq("dis_r", 32'(out_r_data), 32'd0);
    check_eq("dis_busy", 32'(busy), 32'd0);
    run = 1'b1;
    step();
    check_eq("reen_active", 32'(active_sel), 32'd0);
    check_eq("reen_busy", 32'(busy), 32'd1);
    for (int g = 0; g < 16; g++) strobe_chk("reen_up0", 0, g);
    strobe_chk("reen_pass", 0, 16);

    // Asynchronous reset mid-PASS
    #3 reset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_l", 32'(out_l_data), 32'd0);
    check_eq("arst_r", 32'(out_r_data), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_active", 32'(active_sel), 32'd0);
    run = 1'b0;
    step();
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) silent_step("post_rst_no_out");

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
